laser_centroid: RTL
===================

Name: laser_centroid

Overview:
- Downstream stage of the per-pixel threshold mask in the laser-chaser pipeline.
- Accumulates x/y coordinate sums and a hit count for every masked pixel in a frame.
- On an end-of-frame pulse, computes the integer centroid (sum/count) with iterative dividers.
- Publishes the laser position to the tracking/servo logic with a one-cycle valid strobe.

Parameters:
- X_W, 11, pixel x-coordinate width (1280-wide frame)
- Y_W, 10, pixel y-coordinate width (720-tall frame)
- CNT_W, 20, hit-count width (>= log2 of pixels per frame)
- MIN_COUNT, 16, minimum hit count for a valid detection (used only with the optional feature)

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous, active-low reset
- x_in  input  X_W  x coordinate of the current pixel
- y_in  input  Y_W  y coordinate of the current pixel
- valid_in  input  1  pixel qualifier
- mask_in  input  1  threshold mask for the current pixel, aligned with x_in/y_in
- tabulate_in  input  1  one-cycle end-of-frame pulse
- x_out  output  X_W  centroid x
- y_out  output  Y_W  centroid y
- found_out  output  1  last tabulation produced a detection
- valid_out  output  1  one-cycle strobe: x_out/y_out/found_out updated
- busy_out  output  1  dividers running

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-low.
- Reset (rst_in low at a clk_in edge):
  - all outputs go to 0: x_out, y_out, found_out, valid_out, busy_out;
  - accumulators and count clear;
  - FSM goes to IDLE.
- Accumulation: runs in every state.
  - When valid_in && mask_in: sum_x += x_in, sum_y += y_in, count += 1.
  - sum_x width is X_W+CNT_W; sum_y width is Y_W+CNT_W. No saturation is needed; widths cover a full frame.
- tabulate_in in IDLE:
  - snapshot sum_x, sum_y and count into the divider operands;
  - clear the accumulators in the same cycle;
  - a pixel with valid_in && mask_in in that same cycle is counted in the closing frame (it is included in the snapshot).
  - If the snapshot count == 0: go to REPORT directly.
  - Otherwise go to DIVIDE.
- tabulate_in in DIVIDE or REPORT: ignored. The accumulators are not cleared, so that frame's hits merge into the next frame.
- FSM states:
  - IDLE: waits for tabulate_in.
  - DIVIDE: busy_out=1. Both dividers start on the cycle after tabulate. The state exits when both dividers report done.
  - REPORT: valid_out=1 for exactly one cycle, then return to IDLE.
- Dividers: restoring, one quotient bit per cycle, sized to the dividend width.
  - X divider takes X_W+CNT_W cycles; Y divider takes Y_W+CNT_W cycles.
  - Total latency from the tabulate edge to valid_out high is X_W+CNT_W+2 cycles (33 with defaults).
  - The quotient is truncated (floor) to X_W / Y_W bits.
- Outputs in REPORT:
  - count == 0: found_out=0; x_out/y_out hold their previous values.
  - Otherwise: found_out=1; x_out/y_out take the quotients.
  - x_out/y_out/found_out are stable between valid_out strobes.
- valid_in low: the pixel is ignored regardless of mask_in.
- Reset mid-DIVIDE: the divide is abandoned, no valid_out is issued, and all state clears.

Optional Feature:
- Macro: LASER_CENTROID_MIN_COUNT_EN.
- Defined: a snapshot count below MIN_COUNT (but > 0) skips DIVIDE and reports found_out=0 with x_out/y_out held. This rejects speckle noise.
- Undefined: any count >= 1 is a detection. The MIN_COUNT parameter is unused.

Decomposition:
- Shared package laser_pkg:
  - default widths X_W/Y_W/CNT_W and derived sum widths;
  - the FSM state enum (IDLE, DIVIDE, REPORT).
- Sub-module seq_divider:
  - parameterised WIDTH;
  - ports: start_in, dividend_in, divisor_in, quotient_out, done_out, busy_out;
  - instantiated twice (x and y).

Test Plan:
- Single masked pixel at (100,50), then tabulate -> valid_out exactly 33 cycles later; x_out=100, y_out=50, found_out=1.
- Masked pixels (10,20),(11,20),(13,21), then tabulate -> x_out=11, y_out=20 (floor of 61/3 for y), found_out=1.
- Tabulate with no masked pixels -> valid_out after 1 cycle (REPORT); found_out=0; x_out/y_out unchanged from the prior frame.
- Masked pixel coincident with tabulate, plus masked pixels during DIVIDE:
  - the coincident pixel is in the current result;
  - the DIVIDE-period pixels appear only in the next frame's result.
- Second tabulate during DIVIDE -> ignored, single valid_out; rst_in low mid-DIVIDE -> no valid_out, all outputs 0 next cycle.
- With LASER_CENTROID_MIN_COUNT_EN: 15 pixels -> found_out=0; 16 pixels at x=200, y=300 -> x_out=200, y_out=300, found_out=1.

Source files
------------

// File: rtl/laser_centroid_pkg.sv
// ============================================================================
// laser_pkg : shared widths and FSM state encoding for laser_centroid
// Revision  : 1.0
// ============================================================================
`default_nettype none

package laser_pkg;

    localparam int X_W_DEF       = 11;
    localparam int Y_W_DEF       = 10;
    localparam int CNT_W_DEF     = 20;
    localparam int MIN_COUNT_DEF = 16;
    localparam int SUM_X_W_DEF   = X_W_DEF + CNT_W_DEF;
    localparam int SUM_Y_W_DEF   = Y_W_DEF + CNT_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/laser_centroid_if.sv
// ============================================================================
// laser_centroid_if : pixel-stream inputs and centroid result outputs
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface laser_centroid_if
    import laser_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
);
    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic           valid_in;
    logic           mask_in;
    logic           tabulate_in;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic           found_out;
    logic           valid_out;
    logic           busy_out;

    modport master (
        output x_in, y_in, valid_in, mask_in, tabulate_in,
        input  x_out, y_out, found_out, valid_out, busy_out
    );

    modport slave (
        input  x_in, y_in, valid_in, mask_in, tabulate_in,
        output x_out, y_out, found_out, valid_out, busy_out
    );
endinterface

`default_nettype wire

// File: rtl/laser_centroid_seq_divider.sv
// ============================================================================
// seq_divider : restoring divider, one quotient bit per cycle (WIDTH cycles)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int WIDTH  = 31,
    parameter int DIV_W  = 20,
    parameter int QUOT_W = 11
) (
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    input  wire logic              start_in,
    input  wire logic [WIDTH-1:0]  dividend_in,
    input  wire logic [DIV_W-1:0]  divisor_in,
    output logic      [QUOT_W-1:0] quotient_out,
    output logic                   done_out,
    output logic                   busy_out
);
    localparam int STEP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  quo;
    logic [DIV_W-1:0]  rem;
    logic [DIV_W-1:0]  dvs;
    logic [STEP_W-1:0] steps;
    logic              running;
    logic              done;

    logic [DIV_W:0]    shifted;
    logic              fits;
    logic [DIV_W-1:0]  diff;

    // The partial remainder always stays below the divisor, so the
    // subtraction result fits in DIV_W bits when it is taken.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs});
        diff    = shifted[DIV_W-1:0] - dvs;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            steps   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start_in) begin
            quo     <= dividend_in;
            rem     <= '0;
            dvs     <= divisor_in;
            steps   <= STEP_W'(WIDTH);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            quo   <= {quo[WIDTH-2:0], fits};
            rem   <= fits ? diff : shifted[DIV_W-1:0];
            steps <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign quotient_out = quo[QUOT_W-1:0];
    assign done_out     = done;
    assign busy_out     = running;

endmodule

`default_nettype wire

// File: rtl/laser_centroid.sv
// ============================================================================
// laser_centroid : per-frame centroid of masked pixels (sum / count)
// Option         : LASER_CENTROID_MIN_COUNT_EN rejects detections below MIN_COUNT
// Revision       : 1.0
// ============================================================================
`default_nettype none

module laser_centroid
    import laser_pkg::*;
#(
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MIN_COUNT = MIN_COUNT_DEF
) (
    input  wire logic       clk_in,
    input  wire logic       rst_in,
    laser_centroid_if.slave bus
);
    localparam int SX_W = X_W + CNT_W;
    localparam int SY_W = Y_W + CNT_W;

`ifdef LASER_CENTROID_MIN_COUNT_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;

    logic [SX_W-1:0]   sum_x;
    logic [SY_W-1:0]   sum_y;
    logic [CNT_W-1:0]  count;
    logic [SX_W-1:0]   sum_x_next;
    logic [SY_W-1:0]   sum_y_next;
    logic [CNT_W-1:0]  count_next;

    logic              hit;
    logic              accept;
    logic              count_ok;
    logic              start;
    logic              detect;

    logic [X_W-1:0]    quot_x;
    logic [Y_W-1:0]    quot_y;
    logic              done_x;
    logic              done_y;
    logic              busy_x;
    logic              busy_y;

    logic [X_W-1:0]    x_reg;
    logic [Y_W-1:0]    y_reg;
    logic              found_reg;
    logic              valid_reg;

    // Running totals including the current pixel, so a hit coincident with
    // tabulate lands in the frame being closed.
    always_comb begin
        hit        = bus.valid_in & bus.mask_in;
        sum_x_next = sum_x;
        sum_y_next = sum_y;
        count_next = count;
        if (hit) begin
            sum_x_next = sum_x + {{CNT_W{1'b0}}, bus.x_in};
            sum_y_next = sum_y + {{CNT_W{1'b0}}, bus.y_in};
            count_next = count + CNT_W'(1);
        end
        accept   = (state == ST_IDLE) && bus.tabulate_in;
        count_ok = (count_next != '0) &&
                   (!MIN_EN || (count_next >= CNT_W'(MIN_COUNT)));
        start    = accept && count_ok;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (accept) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else begin
            sum_x <= sum_x_next;
            sum_y <= sum_y_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state  <= ST_IDLE;
            detect <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                detect <= count_ok;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = count_ok ? ST_DIVIDE : ST_REPORT;
                end
            end
            ST_DIVIDE: begin
                if (done_x && done_y) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    seq_divider #(
        .WIDTH  (SX_W),
        .DIV_W  (CNT_W),
        .QUOT_W (X_W)
    ) u_div_x (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start),
        .dividend_in  (sum_x_next),
        .divisor_in   (count_next),
        .quotient_out (quot_x),
        .done_out     (done_x),
        .busy_out     (busy_x)
    );

    seq_divider #(
        .WIDTH  (SY_W),
        .DIV_W  (CNT_W),
        .QUOT_W (Y_W)
    ) u_div_y (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start),
        .dividend_in  (sum_y_next),
        .divisor_in   (count_next),
        .quotient_out (quot_y),
        .done_out     (done_y),
        .busy_out     (busy_y)
    );

    // Result registers only move on the report cycle; a miss keeps the last position.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            x_reg     <= '0;
            y_reg     <= '0;
            found_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= (state == ST_REPORT);
            if (state == ST_REPORT) begin
                found_reg <= detect;
                if (detect) begin
                    x_reg <= quot_x;
                    y_reg <= quot_y;
                end
            end
        end
    end

    assign bus.x_out     = x_reg;
    assign bus.y_out     = y_reg;
    assign bus.found_out = found_reg;
    assign bus.valid_out = valid_reg;
    assign bus.busy_out  = (state == ST_DIVIDE) | busy_x | busy_y;

endmodule

`default_nettype wire
